md_unit: RTL and testbench



---
 rtl/md_pkg.sv | 24 ++
 rtl/md_unit.sv | 121 ++++++++++++
 tb/tb_md_unit.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op and state encodings,
// default latencies and a small sizing helper.
package md_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'd0,
    MD_MULTU = 2'd1,
    MD_DIV   = 2'd2,
    MD_DIVU  = 2'd3
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  localparam int unsigned MD_MULT_CYCLES_DEF = 5;
  localparam int unsigned MD_DIV_CYCLES_DEF  = 10;

  function automatic int unsigned md_max(input int unsigned x, input int unsigned y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit: owns HI/LO, computes MULT/MULTU/DIV/DIVU into
// pending registers at launch and commits them after a fixed busy latency.
import md_pkg::*;

module md_unit #(
  parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned CW = $clog2(md_max(MULT_CYCLES, DIV_CYCLES) + 1);

  md_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic             pend_we_q, pend_we_d;

  logic             b_zero;
  logic [63:0]      prod_s, prod_u;
  logic signed [32:0] dvs_s;
  logic [31:0]      quo_s, rem_s, dvs_u, quo_u, rem_u;

  // 33-bit signed divide so 0x80000000 / -1 yields 0x80000000 without overflow;
  // a zero divisor is replaced by 1 since its result is never committed.
  always_comb begin
    b_zero = (b == '0);
    prod_s = 64'($signed(a)) * 64'($signed(b));
    prod_u = {32'd0, a} * {32'd0, b};
    dvs_s  = b_zero ? 33'sd1 : 33'($signed(b));
    quo_s  = 32'(33'($signed(a)) / dvs_s);
    rem_s  = 32'(33'($signed(a)) % dvs_s);
    dvs_u  = b_zero ? 32'd1 : b;
    quo_u  = a / dvs_u;
    rem_u  = a % dvs_u;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_we_d = pend_we_q;
    case (state_q)
      MD_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          state_d   = MD_RUN;
          pend_we_d = 1'b1;
          cnt_d     = op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
          case (op)
            MD_MULT:  {pend_hi_d, pend_lo_d} = prod_s;
            MD_MULTU: {pend_hi_d, pend_lo_d} = prod_u;
            MD_DIV: begin
              pend_we_d = ~b_zero;
              pend_hi_d = rem_s;
              pend_lo_d = quo_s;
            end
            MD_DIVU: begin
              pend_we_d = ~b_zero;
              pend_hi_d = rem_u;
              pend_lo_d = quo_u;
            end
          endcase
        end
      end
      MD_RUN: begin
        if (cnt_q == CW'(1)) begin
          state_d = MD_IDLE;
          cnt_d   = '0;
          if (pend_we_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_we_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_we_q <= pend_we_d;
    end
  end

  assign busy = (state_q == MD_RUN);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_md_unit;
  import md_pkg::*;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = '0;
  logic [31:0] a = '0, b = '0, wdata = '0;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic        busy;
  logic [31:0] hi, lo;

  always #5 clk = ~clk;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .hi(hi), .lo(lo)
  );

  int unsigned n_err = 0;
  int unsigned n_chk = 0;

  task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: architectural HI/LO, a result waiting to land, and the
  // number of busy cycles still to run.
  logic [31:0] m_hi = '0, m_lo = '0, r_hi = '0, r_lo = '0;
  logic        r_we = 1'b0;
  int          m_left = 0;

  function automatic void ref_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                 output logic we, output logic [31:0] rh, output logic [31:0] rl);
    int      ix, iy;
    longint  sx, sy, p, q, r;
    longint unsigned ux, uy, up;
    ix = x; iy = y; sx = ix; sy = iy; ux = x; uy = y;
    we = 1'b1; rh = '0; rl = '0;
    case (o)
      2'd0: begin p = sx * sy; rh = p[63:32]; rl = p[31:0]; end
      2'd1: begin up = ux * uy; rh = up[63:32]; rl = up[31:0]; end
      2'd2: if (y == 0) we = 1'b0; else begin q = sx / sy; r = sx % sy; rl = q[31:0]; rh = r[31:0]; end
      default: if (y == 0) we = 1'b0; else begin up = ux / uy; rl = up[31:0]; up = ux % uy; rh = up[31:0]; end
    endcase
  endfunction

  function automatic void model_edge();
    if (!reset) begin
      m_hi = '0; m_lo = '0; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && r_we) begin m_hi = r_hi; m_lo = r_lo; end
    end else begin
      if (hi_we) m_hi = wdata;
      if (lo_we) m_lo = wdata;
      if (start) begin
        ref_op(op, a, b, r_we, r_hi, r_lo);
        m_left = op[1] ? int'(DC) : int'(MC);
      end
    end
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check32("busy", {31'd0, busy}, {31'd0, m_left > 0});
    check32("hi", hi, m_hi);
    check32("lo", lo, m_lo);
  endtask

  // Launch one op and return the number of busy cycles seen on the DUT.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int unsigned n);
    start = 1'b1; op = o; a = x; b = y;
    step();
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      step();
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'd0;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  int unsigned n;

  initial begin
    @(negedge clk);
    check32("rst_busy", {31'd0, busy}, 32'd0);
    check32("rst_hi", hi, 32'd0);
    check32("rst_lo", lo, 32'd0);
    reset = 1'b1;
    step();

    run_op(2'd0, 32'hFFFF_FFFF, 32'd2, n);
    check32("mult_len", n, MC);
    check32("mult_hi", hi, 32'hFFFF_FFFF);
    check32("mult_lo", lo, 32'hFFFF_FFFE);

    run_op(2'd1, 32'hFFFF_FFFF, 32'd2, n);
    check32("multu_len", n, MC);
    check32("multu_hi", hi, 32'h0000_0001);
    check32("multu_lo", lo, 32'hFFFF_FFFE);

    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, n);
    check32("div_len", n, DC);
    check32("div_lo", lo, 32'hFFFF_FFFD);
    check32("div_hi", hi, 32'hFFFF_FFFF);

    run_op(2'd3, 32'd7, 32'd0, n);
    check32("div0_len", n, DC);
    check32("div0_lo", lo, 32'hFFFF_FFFD);
    check32("div0_hi", hi, 32'hFFFF_FFFF);

    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, n);
    check32("ovf_lo", lo, 32'h8000_0000);
    check32("ovf_hi", hi, 32'd0);

    hi_we = 1'b1; wdata = 32'h1234_5678;
    step();
    hi_we = 1'b0;
    check32("mthi", hi, 32'h1234_5678);

    // MTHI and a conflicting start during busy are both dropped.
    start = 1'b1; op = 2'd0; a = 32'd3; b = 32'd4;
    step();
    start = 1'b1; op = 2'd3; a = 32'd50; b = 32'd3;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
    step();
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin n++; step(); end
    check32("ign_hi", hi, 32'd0);
    check32("ign_lo", lo, 32'd12);

    run_op(2'd0, 32'd3, 32'd4, n);
    check32("b2b_lo1", lo, 32'd12);
    run_op(2'd3, 32'd100, 32'd7, n);
    check32("b2b_len", n, DC);
    check32("b2b_lo2", lo, 32'd14);
    check32("b2b_hi2", hi, 32'd2);

    start = 1'b1; op = 2'd2; a = 32'd1000; b = 32'd3;
    step();
    start = 1'b0;
    step();
    step();
    reset = 1'b0;
    #1;
    check32("arst_busy", {31'd0, busy}, 32'd0);
    check32("arst_hi", hi, 32'd0);
    check32("arst_lo", lo, 32'd0);
    step();
    reset = 1'b1;
    run_op(2'd0, 32'd2, 32'd3, n);
    check32("post_rst_len", n, MC);
    check32("post_rst_lo", lo, 32'd6);
    check32("post_rst_hi", hi, 32'd0);

    for (int i = 0; i < 600; i++) begin
      start = ($urandom_range(0, 3) == 0);
      op    = 2'($urandom_range(0, 3));
      a     = pick();
      b     = pick();
      hi_we = ($urandom_range(0, 6) == 0);
      lo_we = ($urandom_range(0, 6) == 0);
      wdata = $urandom;
      step();
    end
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
